// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit with HI/LO result registers.
// One multiply shift-add or restoring divide step per clock. The fixed latency
// is WIDTH+1 cycles. Divide-by-zero skips the iterations. MADD/MSUB fold the
// product into {hi,lo}. mthi/mtlo writes are accepted only while idle.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // Two's-complement magnitude when the operand is treated as signed
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    state_t           state_r, state_s;
    logic [2:0]       op_r;
    logic [W2-1:0]    acc_r;       // product accumulator, or {remainder, quotient}
    logic [W2-1:0]    mcand_r;     // left-shifting multiplicand
    logic [WIDTH-1:0] mplier_r;    // right-shifting multiplier, or divisor
    logic [CW-1:0]    cnt_r;
    logic             neg_q_r;     // negate product / quotient at FIX
    logic             neg_r_r;     // negate remainder at FIX
    logic             div0_r;
    logic             busy_r, done_r, dz_r;
    logic [WIDTH-1:0] hi_r, lo_r;

    logic             accept_s, in_div_s, in_signed_s, div0_s, r_div_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s, quo_s, rem_s;
    logic [WIDTH:0]   trial_s;
    logic [W2-1:0]    acc_step_s, prod_s, hilo_s, result_s;

    // Operand decode, one iteration step and the FIX-stage result
    always_comb begin
        accept_s    = start && (state_r == S_IDLE);
        in_div_s    = (op[2:1] == 2'b01);
        in_signed_s = ~op[0];
        div0_s      = in_div_s && (b == {WIDTH{1'b0}});
        a_mag_s     = mag(a, in_signed_s);
        b_mag_s     = mag(b, in_signed_s);
        r_div_s     = (op_r[2:1] == 2'b01);

        // restoring divide: shifted remainder (W+1 bits) minus divisor
        trial_s = acc_r[W2-1:WIDTH-1] - {1'b0, mplier_r};
        if (r_div_s) begin
            if (!trial_s[WIDTH]) begin
                acc_step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {acc_r[W2-2:0], 1'b0};
            end
        end else begin
            acc_step_s = acc_r + (mplier_r[0] ? mcand_r : {W2{1'b0}});
        end

        quo_s  = neg_q_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
        rem_s  = neg_r_r ? -acc_r[W2-1:WIDTH] : acc_r[W2-1:WIDTH];
        prod_s = neg_q_r ? -acc_r : acc_r;
        hilo_s = {hi_r, lo_r};
        if (r_div_s) begin
            result_s = {rem_s, quo_s};
        end else if (op_r[2]) begin
            result_s = op_r[1] ? (hilo_s - prod_s) : (hilo_s + prod_s);
        end else begin
            result_s = prod_s;
        end
    end

    // Next-state logic: IDLE -> CALC -> FIX -> IDLE, divide-by-zero skips CALC
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_s = div0_s ? S_FIX : S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (cnt_r == {CW{1'b0}}) begin
                    state_s = S_FIX;
                end else begin
                    state_s = S_CALC;
                end
            end
            S_FIX:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, HI/LO registers and registered status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r     <= 3'd0;
            acc_r    <= {W2{1'b0}};
            mcand_r  <= {W2{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dz_r     <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
        end else begin
            busy_r <= (state_s != S_IDLE);
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r     <= op;
                        neg_q_r  <= in_signed_s && (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r_r  <= in_signed_s && a[WIDTH-1];
                        div0_r   <= div0_s;
                        dz_r     <= 1'b0;
                        cnt_r    <= CNT_LAST;
                        mplier_r <= b_mag_s;
                        if (in_div_s) begin
                            acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                            mcand_r <= {W2{1'b0}};
                        end else begin
                            acc_r   <= {W2{1'b0}};
                            mcand_r <= {{WIDTH{1'b0}}, a_mag_s};
                        end
                    end else begin
                        if (hi_wr) hi_r <= a;
                        if (lo_wr) lo_r <= a;
                    end
                end
                S_CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r - CW'(1);
                    if (!r_div_s) begin
                        mcand_r  <= {mcand_r[W2-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    done_r <= 1'b1;
                    if (div0_r) begin
                        dz_r <= 1'b1;
                    end else begin
                        hi_r <= result_s[W2-1:WIDTH];
                        lo_r <= result_s[WIDTH-1:0];
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign dz   = dz_r;
    assign hi   = hi_r;
    assign lo   = lo_r;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: scoreboard bench for mdu_iter (WIDTH=32). The stimulus pushes
// the expected {hi,lo,dz} from an arithmetic reference model. A monitor pops
// the entry and compares it on every done pulse.
module tb_mdu_iter;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        hi_wr = 1'b0;
    logic        lo_wr = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .hi_wr(hi_wr), .lo_wr(lo_wr), .a(a), .b(b),
        .busy(busy), .done(done), .dz(dz), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, pushes the expected result
    task automatic model(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
        logic signed [63:0] sa, sb, q, r;
        logic [63:0] p;
        exp_t e;
        sa = {{32{av[31]}}, av};
        sb = {{32{bv[31]}}, bv};
        e.dz = 1'b0;
        if (o[2:1] == 2'b01) begin
            if (bv == 32'd0) begin
                e.dz = 1'b1;
            end else if (!o[0]) begin
                q = sa / sb;
                r = sa % sb;
                lo_m = q[31:0];
                hi_m = r[31:0];
            end else begin
                lo_m = av / bv;
                hi_m = av % bv;
            end
        end else begin
            if (!o[0]) p = sa * sb;
            else       p = {32'd0, av} * {32'd0, bv};
            if (o[2] && o[1])  p = {hi_m, lo_m} - p;
            else if (o[2])     p = {hi_m, lo_m} + p;
            hi_m = p[63:32];
            lo_m = p[31:0];
        end
        e.hi = hi_m;
        e.lo = lo_m;
        sb_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("dz", 64'(dz), 64'(e.dz));
            end
        end
    end

    // Issue one op with optional interference while it is in flight
    task automatic run_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input bit with_lowr, input int inj_at, input bit inj_start,
                          input bit inj_hiwr);
        int n;
        int exp_busy;
        @(negedge clk);
        start = 1'b1; op = o; a = av; b = bv; lo_wr = with_lowr; hi_wr = 1'b0;
        model(o, av, bv);
        exp_busy = (o[2:1] == 2'b01 && bv == 32'd0) ? 1 : 33;
        @(negedge clk);
        start = 1'b0; lo_wr = 1'b0;
        op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        n = 0;
        while (busy && n < 100) begin
            if (n == inj_at) begin
                start = inj_start; hi_wr = inj_hiwr;
            end else begin
                start = 1'b0; hi_wr = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0; hi_wr = 1'b0;
        chk("busy_cycles", 64'(n), 64'(exp_busy));
        chk("done_set", 64'(done), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
    endtask

    task automatic mtx(input bit h, input bit l, input logic [31:0] v);
        @(negedge clk);
        hi_wr = h; lo_wr = l; a = v; start = 1'b0;
        @(negedge clk);
        hi_wr = 1'b0; lo_wr = 1'b0;
        if (h) hi_m = v;
        if (l) lo_m = v;
        chk("mt_hi", 64'(hi), 64'(hi_m));
        chk("mt_lo", 64'(lo), 64'(lo_m));
    endtask

    function automatic logic [31:0] pick(input bit allow_zero);
        int s;
        s = $urandom_range(0, 6);
        case (s)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            3: return allow_zero ? 32'd0 : 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Main stimulus: reset, directed cases, reset mid-op, then random ops
    initial begin
        bit saw_done;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(dz), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, -1, 1'b0, 1'b0);          // MULT -3*7
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, -1, 1'b0, 1'b0);          // DIV -7/2
        run_op(3'd3, 32'h8000_0000, 32'd0, 1'b0, 0, 1'b1, 1'b0);           // DIVU /0
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, -1, 1'b0, 1'b0);  // MIN/-1
        run_op(3'd3, 32'hFFFF_FFFF, 32'h10, 1'b0, -1, 1'b0, 1'b0);         // DIVU
        mtx(1'b1, 1'b1, 32'd0);
        mtx(1'b0, 1'b1, 32'd5);
        run_op(3'd4, 32'd2, 32'd3, 1'b0, -1, 1'b0, 1'b0);                  // MADD
        mtx(1'b1, 1'b1, 32'd0);
        run_op(3'd7, 32'd1, 32'd1, 1'b0, -1, 1'b0, 1'b0);                  // MSUBU
        run_op(3'd0, 32'd12345, 32'hFFFF_0001, 1'b0, 5, 1'b1, 1'b0);       // start while busy
        run_op(3'd1, 32'hDEAD_BEEF, 32'd77, 1'b0, 9, 1'b0, 1'b1);          // hi_wr while busy
        run_op(3'd5, 32'd9, 32'd9, 1'b1, -1, 1'b0, 1'b0);                  // start+lo_wr

        // reset in the middle of a DIV: no result, no done pulse
        mtx(1'b1, 1'b1, 32'h1234_5678);
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi", 64'(hi), 64'd0);
        chk("rst_mid_lo", 64'(lo), 64'd0);
        chk("rst_mid_dz", 64'(dz), 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("rst_mid_no_done", 64'(saw_done), 64'd0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mtx(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            end
            run_op(3'($urandom_range(0, 7)), pick(1'b0), pick(1'b1),
                   1'($urandom_range(0, 1)), $urandom_range(0, 40),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
